// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types for the pipeline front end.
// Holds the reset PC, the canonical NOP, opcode encodings and the fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0] OPCODE_R    = 7'b0110011;
    localparam logic [6:0] OPCODE_S    = 7'b0100011;
    localparam logic [6:0] OPCODE_SB   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; low two bits are forced to zero.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds when disabled,
// and collapses to a NOP bubble on flush or when enabled with nothing to load.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic        load_valid,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
);

    // A bubble keeps the previous PC; only valid entries carry a meaningful PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_pc    <= RESET_PC;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (enable) begin
            if (load_valid) begin
                if_id_pc    <= load_pc;
                if_id_inst  <= load_inst;
                if_id_valid <= 1'b1;
            end else begin
                if_id_inst  <= NOP_INST;
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM, PC, stall hold buffer
// and branch redirect handling, feeding the IF/ID register.
module if_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_enable,
    input  logic        if_id_enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  hold_buf, hold_buf_next;
    logic         issue_req;
    logic         deliver;
    logic [31:0]  deliver_inst;
    logic         flush;
    logic         both_en;

    assign both_en   = pc_enable & if_id_enable;
    assign imem_req  = issue_req & ~rst;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ISSUE;
            pc       <= RESET_PC;
            hold_buf <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            hold_buf <= hold_buf_next;
        end
    end

    // A redirect outranks everything; in ISSUE it also suppresses the request so
    // that no orphaned response can ever arrive.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        hold_buf_next = hold_buf;
        issue_req     = 1'b0;
        deliver       = 1'b0;
        deliver_inst  = hold_buf;
        flush         = 1'b0;

        if (branch_taken) begin
            pc_next       = align_word(branch_target);
            hold_buf_next = '0;
            flush         = 1'b1;
            unique case (state)
                WAIT:    state_next = imem_rvalid ? ISSUE : DROP;
                DROP:    state_next = imem_rvalid ? ISSUE : DROP;
                default: state_next = ISSUE;
            endcase
        end else begin
            unique case (state)
                ISSUE: begin
                    issue_req  = 1'b1;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (both_en) begin
                            deliver      = 1'b1;
                            deliver_inst = imem_rdata;
                        end else begin
                            hold_buf_next = imem_rdata;
                            state_next    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (both_en) begin
                        deliver      = 1'b1;
                        deliver_inst = hold_buf;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_next = ISSUE;
                    end
                end
                default: state_next = ISSUE;
            endcase

            if (deliver) begin
                pc_next    = pc + 32'd4;
                state_next = ISSUE;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .enable      (if_id_enable),
        .flush       (flush),
        .load_valid  (deliver),
        .load_pc     (pc),
        .load_inst   (deliver_inst),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random traffic,
// with a behavioural fetch model and a one-slot instruction memory model.
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        pc_enable;
    logic        if_id_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;

    int vectors;
    int miscompares;
    int cyc;

    // Memory model: one pending request, answered after a chosen latency
    bit          mem_busy;
    int          mem_due;
    logic [31:0] mem_addr;
    int          mem_lat_fixed;
    bit          inject_stale;

    // Reference model: what the fetch unit is waiting for, plus IF/ID contents
    logic [31:0] m_pc;
    bit          m_need_issue;
    bit          m_pending;
    bit          m_squash;
    bit          m_full;
    logic [31:0] m_buf;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_inst;
    bit          m_ifid_valid;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_enable     (pc_enable),
        .if_id_enable  (if_id_enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_inst    (if_id_inst),
        .if_id_valid   (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit pe, input bit ie,
                                 input bit br, input logic [31:0] tgt);
        bit          rv;
        bit          exp_req;
        bit          deliver;
        logic [31:0] rd;
        logic [31:0] word;

        @(negedge clk);
        cyc++;
        rv = mem_busy && (cyc == mem_due);
        rd = rv ? mem_word(mem_addr) : $urandom;
        if (rv) mem_busy = 1'b0;
        if (inject_stale) begin
            rv = 1'b1;
            rd = 32'hDEAD_BEEF;
        end
        rst           = r;
        pc_enable     = pe;
        if_id_enable  = ie;
        branch_taken  = br;
        branch_target = tgt;
        imem_rvalid   = rv;
        imem_rdata    = rd;
        #1;

        exp_req = !r && m_need_issue && !br;
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) checkOutput("imem_addr", imem_addr, m_pc);
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_due  = cyc + ((mem_lat_fixed != 0) ? mem_lat_fixed : int'($urandom_range(1, 3)));
            mem_addr = imem_addr;
        end

        deliver = 1'b0;
        word    = '0;
        if (r) begin
            m_pc         = RESET_PC;
            m_need_issue = 1'b1;
            m_pending    = 1'b0;
            m_squash     = 1'b0;
            m_full       = 1'b0;
            m_buf        = '0;
            m_ifid_pc    = 32'h0;
            m_ifid_inst  = NOP_INST;
            m_ifid_valid = 1'b0;
        end else if (br) begin
            m_full       = 1'b0;
            m_ifid_inst  = NOP_INST;
            m_ifid_valid = 1'b0;
            m_pc         = tgt & ~32'h3;
            if (m_squash) begin
                if (rv) begin
                    m_squash     = 1'b0;
                    m_need_issue = 1'b1;
                end
            end else if (m_pending && !rv) begin
                m_pending = 1'b0;
                m_squash  = 1'b1;
            end else begin
                m_pending    = 1'b0;
                m_need_issue = 1'b1;
            end
        end else begin
            if (m_need_issue) begin
                m_need_issue = 1'b0;
                m_pending    = 1'b1;
            end else if (m_squash) begin
                if (rv) begin
                    m_squash     = 1'b0;
                    m_need_issue = 1'b1;
                end
            end else if (m_pending) begin
                if (rv) begin
                    m_pending = 1'b0;
                    if (pe && ie) begin
                        deliver = 1'b1;
                        word    = rd;
                    end else begin
                        m_full = 1'b1;
                        m_buf  = rd;
                    end
                end
            end else if (m_full) begin
                if (pe && ie) begin
                    deliver = 1'b1;
                    word    = m_buf;
                    m_full  = 1'b0;
                end
            end
            if (deliver) begin
                m_ifid_pc    = m_pc;
                m_ifid_inst  = word;
                m_ifid_valid = 1'b1;
                m_pc         = m_pc + 32'd4;
                m_need_issue = 1'b1;
            end else if (ie) begin
                m_ifid_inst  = NOP_INST;
                m_ifid_valid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifid_valid});
        checkOutput("if_id_inst", if_id_inst, m_ifid_inst);
        if (m_ifid_valid || r) checkOutput("if_id_pc", if_id_pc, m_ifid_pc);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        mem_busy      = 1'b0;
        mem_due       = 0;
        mem_addr      = '0;
        mem_lat_fixed = 1;
        inject_stale  = 1'b0;
        rst           = 1'b1;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;

        $display("[TB] reset");
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("reset_if_id_pc", if_id_pc, 32'h0);

        $display("[TB] streaming with 1-cycle memory");
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("stream_last_pc", if_id_pc, 32'h8);

        $display("[TB] stall while response arrives");
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("held_pc", if_id_pc, 32'hC);
        checkOutput("held_inst", if_id_inst, mem_word(32'hC));

        $display("[TB] redirect in WAIT with late response");
        mem_lat_fixed = 3;
        applyStimulus(0, 1, 1, 0, 0);
        mem_lat_fixed = 1;
        applyStimulus(0, 1, 1, 1, 32'h0000_0103);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("redirect_addr", imem_addr, 32'h0000_0100);

        $display("[TB] redirect and stall together");
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_0200);
        checkOutput("flush_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("flush_inst", if_id_inst, NOP_INST);

        $display("[TB] pc wrap");
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("wrap_addr", imem_addr, 32'h0);

        $display("[TB] reset during WAIT");
        mem_lat_fixed = 2;
        applyStimulus(0, 1, 1, 0, 0);
        mem_lat_fixed = 1;
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        inject_stale = 1'b1;
        applyStimulus(0, 1, 1, 0, 0);
        inject_stale = 1'b0;
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("restart_pc", if_id_pc, 32'h0);
        checkOutput("restart_inst", if_id_inst, mem_word(32'h0));

        $display("[TB] random traffic");
        mem_lat_fixed = 0;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(0,
                          ($urandom_range(0, 4) != 0),
                          ($urandom_range(0, 4) != 0),
                          ($urandom_range(0, 15) == 0),
                          $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 pc_enable  in  1  from hazard unit; 1 = PC may advance.
REQ-004 if_id_enable  in  1  from hazard unit; 1 = IF/ID register may load.
REQ-005 branch_taken  in  1  redirect request from ID/EX.
REQ-006 branch_target  in  32  redirect address.
REQ-007 imem_req  out  1  single-cycle fetch request to instruction memory.
REQ-008 imem_addr  out  32  fetch address, valid when imem_req=1.
REQ-009 imem_rvalid  in  1  instruction data valid; earliest 1 cycle after imem_req.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 if_id_pc  out  32  PC of the instruction in IF/ID.
REQ-012 if_id_inst  out  32  instruction in IF/ID; opcode field drives hazard unit inst_opcode.
REQ-013 if_id_valid  out  1  1 = if_id_inst is a real fetched instruction.

Function
REQ-014 The FSM SHALL have states ISSUE, WAIT, HOLD and DROP, with at most one request outstanding.
REQ-015 ISSUE: imem_req=1 and imem_addr=pc for exactly one cycle; next state WAIT.
REQ-016 WAIT, imem_rvalid=1, pc_enable=1 and if_id_enable=1: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4; next state ISSUE.
REQ-017 WAIT, imem_rvalid=1, either enable low: word captured in a 32-bit hold buffer; pc unchanged; next state HOLD.
REQ-018 HOLD, pc_enable=1 and if_id_enable=1: IF/ID <= {pc, hold buffer, valid=1}; pc <= pc+4; next state ISSUE.
REQ-019 A cycle with if_id_enable=1 and no instruction delivered SHALL load a bubble: if_id_valid=0, if_id_inst=32'h00000013 (NOP).
REQ-020 A cycle with if_id_enable=0 SHALL hold all IF/ID outputs unchanged.
REQ-021 branch_taken=1 SHALL take priority over all other events in that cycle.
REQ-022 On a redirect: pc <= {branch_target[31:2], 2'b00}; IF/ID flushed to the bubble value (REQ-019) regardless of if_id_enable; hold buffer discarded.
REQ-023 Redirect state transitions: from WAIT without imem_rvalid -> DROP; from WAIT with imem_rvalid, or from ISSUE or HOLD -> ISSUE (the ISSUE-cycle request is abandoned).
REQ-024 DROP: the next imem_rvalid is discarded, then next state ISSUE; a further redirect in DROP updates pc only.
REQ-025 imem_rvalid in ISSUE or HOLD SHALL be ignored.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).

Reset
REQ-027 While rst=1: pc=RESET_PC (32'h00000000), state=ISSUE, imem_req=0, if_id_pc=0, if_id_inst=NOP, if_id_valid=0, hold buffer cleared.
REQ-028 The first imem_req SHALL occur in the first cycle after rst deasserts; rst asserted mid-request SHALL abandon it, and any later imem_rvalid for it SHALL be ignored.

Structure
REQ-029 RESET_PC, NOP_INST and the opcode constants (R, S, SB, I-load) SHALL live in the shared riscv_pkg.
REQ-030 The IF/ID register (load, hold, flush) SHALL be a sub-module named if_id_reg; the FSM, PC and hold buffer stay in if_stage.

Verification
REQ-031 Reset, no stalls, 1-cycle memory: imem_addr sequence 0,4,8; IF/ID updates every 2 cycles; if_id_valid=1.
REQ-032 if_id_enable=0 and pc_enable=0 for 3 cycles while a response arrives: state HOLD, IF/ID frozen; on release, the held word loads with if_id_pc=the stalled pc.
REQ-033 branch_taken in WAIT with target 32'h00000103, response 2 cycles later: response dropped, next imem_addr=32'h00000100, if_id_valid=0 during the gap.
REQ-034 branch_taken and a stall in the same cycle: redirect wins; IF/ID flushed to NOP.
REQ-035 pc preset to 32'hFFFFFFFC: after one delivered instruction, the next imem_addr=32'h00000000.
REQ-036 rst asserted while in WAIT, imem_rvalid returned afterwards: outputs at reset values, data ignored, fetch restarts at 0.
